// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-only memory port: sub-word loads extract and extend, sub-word stores do read-modify-write.
// Optional MEM_ACCESS_ALIGN_CHECK_EN flags misaligned halfword/word requests with resp_err instead of accessing memory.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       Address,
  output logic [31:0]       Write_data,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [31:0]       Mem_data
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // READ  | MemRead high, Mem_data captured at closing edge
  // WRITE | MemWrite high for one cycle
  // RESP  | resp_valid pulse
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wr_word_q, wr_word_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        we_q, we_d;
  logic        err_q, err_d;

  logic [31:0] addr_ext;
  logic        accept;
  logic        misaligned;

  assign addr_ext = 32'(req_addr);
  assign accept   = req_valid && (state_q == IDLE);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign misaligned = ((req_size == 2'd1) && addr_ext[0]) ||
                      (req_size[1] && (addr_ext[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] off, input logic sgn);
    logic [31:0] lane;
    logic [31:0] res;
    res = word;
    if (size == 2'd0) begin
      lane = word >> {off, 3'b000};
      res  = {{24{sgn & lane[7]}}, lane[7:0]};
    end else if (size == 2'd1) begin
      lane = word >> {off[1], 4'b0000};
      res  = {{16{sgn & lane[15]}}, lane[15:0]};
    end
    return res;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [15:0] wdata,
                                        input logic [1:0] size, input logic [1:0] off);
    logic [31:0] mask;
    logic [31:0] data;
    if (size == 2'd0) begin
      mask = 32'h0000_00ff << {off, 3'b000};
      data = {24'h0, wdata[7:0]} << {off, 3'b000};
    end else begin
      mask = 32'h0000_ffff << {off[1], 4'b0000};
      data = {16'h0, wdata} << {off[1], 4'b0000};
    end
    return (word & ~mask) | data;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wr_word_q <= '0;
      rdata_q   <= '0;
      wdata_q   <= '0;
      off_q     <= '0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_word_q <= wr_word_d;
      rdata_q   <= rdata_d;
      wdata_q   <= wdata_d;
      off_q     <= off_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      we_q      <= we_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misaligned)                 state_d = RESP;
          else if (req_we && req_size[1]) state_d = WRITE;
          else                            state_d = READ;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured once at acceptance; the bus word is built from them afterwards.
  always_comb begin
    addr_d    = addr_q;
    wr_word_d = wr_word_q;
    rdata_d   = rdata_q;
    wdata_d   = wdata_q;
    off_d     = off_q;
    size_d    = size_q;
    signed_d  = signed_q;
    we_d      = we_q;
    err_d     = err_q;
    if (accept) begin
      addr_d   = {addr_ext[31:2], 2'b00};
      off_d    = addr_ext[1:0];
      size_d   = req_size;
      signed_d = req_signed;
      we_d     = req_we;
      wdata_d  = req_wdata[15:0];
      rdata_d  = '0;
      err_d    = misaligned;
      if (req_we && req_size[1] && !misaligned) wr_word_d = req_wdata;
    end else if (state_q == READ) begin
      if (we_q) wr_word_d = merge(Mem_data, wdata_q, size_q, off_q);
      else      rdata_d   = extract(Mem_data, size_q, off_q, signed_q);
    end
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    MemRead    = (state_q == READ);
    MemWrite   = (state_q == WRITE);
    resp_valid = (state_q == RESP);
    resp_err   = err_q && (state_q == RESP);
    resp_rdata = rdata_q;
    Address    = addr_q;
    Write_data = wr_word_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory model on the bus, byte-array reference model for expected results.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, Address, Write_data, Mem_data;
  logic        MemRead, MemWrite;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];
  logic [7:0]  ref_mem [0:255];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_word = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .Address(Address), .Write_data(Write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .Mem_data(Mem_data)
  );

  assign Mem_data = mem[Address[7:2]];

  always @(posedge clk) begin
    if (MemWrite)    mem[Address[7:2]] <= Write_data;
    else if (pre_en) mem[pre_idx] <= pre_word;
  end

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    logic [7:0] b;
    b = a & 8'hfc;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] a, input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [31:0] v;
    if (size == 2'd0) begin
      v = {24'h0, ref_mem[a]};
      if (sgn && v[7]) v = v | 32'hffff_ff00;
    end else if (size == 2'd1) begin
      b = a & 8'hfe;
      v = {16'h0, ref_mem[b+1], ref_mem[b]};
      if (sgn && v[15]) v = v | 32'hffff_0000;
    end else begin
      v = ref_word(a);
    end
    return v;
  endfunction

  task automatic model_store(input logic [7:0] a, input logic [1:0] size, input logic [31:0] d);
    logic [7:0] b;
    if (size == 2'd0) begin
      ref_mem[a] = d[7:0];
    end else if (size == 2'd1) begin
      b = a & 8'hfe;
      ref_mem[b] = d[7:0]; ref_mem[b+1] = d[15:8];
    end else begin
      b = a & 8'hfc;
      for (int i = 0; i < 4; i++) ref_mem[b+i] = d[8*i +: 8];
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] w);
    logic [7:0] b;
    b = a & 8'hfc;
    for (int i = 0; i < 4; i++) ref_mem[b+i] = w[8*i +: 8];
    @(negedge clk);
    pre_idx = b[7:2]; pre_word = w; pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got_rdata, output logic got_err);
    logic        mis, seen, both, ready_seen;
    int          exp_lat, exp_rd, exp_wr, n, rd_cnt, wr_cnt;
    logic [31:0] exp_rdata, got_addr, got_wd;
    mis = ALIGN_EN && (((size == 2'd1) && addr[0]) || (size[1] && (addr[1:0] != 2'b00)));
    exp_rdata = 32'h0;
    if (mis)              begin exp_lat = 1; exp_rd = 0; exp_wr = 0; end
    else if (!we)         begin exp_lat = 2; exp_rd = 1; exp_wr = 0; exp_rdata = model_load(addr[7:0], size, sgn); end
    else if (size[1])     begin exp_lat = 2; exp_rd = 0; exp_wr = 1; end
    else                  begin exp_lat = 3; exp_rd = 1; exp_wr = 1; end

    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_before_req: ready=%b resp_valid=%b required ready=1 resp_valid=0", req_ready, resp_valid);
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = $urandom; req_size = 2'($urandom); req_signed = $urandom;
    req_addr = $urandom; req_wdata = $urandom;

    seen = 1'b0; both = 1'b0; ready_seen = 1'b0; rd_cnt = 0; wr_cnt = 0; n = 1;
    got_rdata = 'x; got_err = 1'bx; got_addr = 'x; got_wd = 'x;
    while (n <= 8 && !seen) begin
      @(negedge clk);
      if (MemRead) rd_cnt++;
      if (MemWrite) wr_cnt++;
      if (MemRead && MemWrite) both = 1'b1;
      if (req_ready) ready_seen = 1'b1;
      if (resp_valid) begin
        seen = 1'b1; got_rdata = resp_rdata; got_err = resp_err;
        got_addr = Address; got_wd = Write_data;
      end else n++;
    end

    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL resp_timeout: addr=%h we=%b size=%0d no resp_valid within 8 cycles", addr, we, size);
      return;
    end
    checks++;
    if (n != exp_lat) begin errors++; $display("FAIL latency: addr=%h got %0d required %0d", addr, n, exp_lat); end
    checks++;
    if (rd_cnt != exp_rd || wr_cnt != exp_wr || both) begin
      errors++;
      $display("FAIL bus_cycles: addr=%h rd=%0d wr=%0d both=%b required rd=%0d wr=%0d both=0", addr, rd_cnt, wr_cnt, both, exp_rd, exp_wr);
    end
    checks++;
    if (ready_seen) begin errors++; $display("FAIL ready_while_busy: addr=%h req_ready seen high, required 0", addr); end
    checks++;
    if (got_rdata !== exp_rdata || got_err !== mis) begin
      errors++;
      $display("FAIL response: addr=%h rdata=%h err=%b required rdata=%h err=%b", addr, got_rdata, got_err, exp_rdata, mis);
    end
    checks++;
    if (got_addr !== {addr[31:2], 2'b00}) begin
      errors++; $display("FAIL address: got %h required %h", got_addr, {addr[31:2], 2'b00});
    end
    if (we && !mis) begin
      model_store(addr[7:0], size, wdata);
      checks++;
      if (got_wd !== ref_word(addr[7:0]) || mem[addr[7:2]] !== ref_word(addr[7:0])) begin
        errors++;
        $display("FAIL store_word: Write_data=%h mem=%h required %h", got_wd, mem[addr[7:2]], ref_word(addr[7:0]));
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || MemRead !== 1'b0 ||
        MemWrite !== 1'b0 || resp_rdata !== 32'h0 || Address !== 32'h0 || Write_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: ready=%b rv=%b err=%b rd=%b wr=%b rdata=%h addr=%h wd=%h required 1 0 0 0 0 0 0 0",
               req_ready, resp_valid, resp_err, MemRead, MemWrite, resp_rdata, Address, Write_data);
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_word_rw();
    logic [31:0] r; logic e;
    do_req(1'b1, 2'd2, 1'b0, 32'h80, 32'h1234_5678, r, e);
    do_req(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, r, e);
    checks++;
    if (r !== 32'h1234_5678) begin errors++; $display("FAIL lw_0x80: got %h required 12345678", r); end
  endtask

  task automatic test_load_ext();
    logic [31:0] r; logic e;
    preload(8'h80, 32'h80FF_7F01);
    do_req(1'b0, 2'd0, 1'b1, 32'h83, 32'h0, r, e);
    checks++; if (r !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_0x83: got %h required ffffff80", r); end
    do_req(1'b0, 2'd0, 1'b0, 32'h83, 32'h0, r, e);
    checks++; if (r !== 32'h0000_0080) begin errors++; $display("FAIL lbu_0x83: got %h required 00000080", r); end
    do_req(1'b0, 2'd0, 1'b1, 32'h81, 32'h0, r, e);
    checks++; if (r !== 32'h0000_007F) begin errors++; $display("FAIL lb_0x81: got %h required 0000007f", r); end
    do_req(1'b0, 2'd1, 1'b1, 32'h82, 32'h0, r, e);
    checks++; if (r !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_0x82: got %h required ffff80ff", r); end
  endtask

  task automatic test_store_sub();
    logic [31:0] r; logic e;
    preload(8'h80, 32'h1122_3344);
    do_req(1'b1, 2'd0, 1'b0, 32'h82, 32'hFFFF_FFAB, r, e);
    checks++; if (mem[32] !== 32'h11AB_3344) begin errors++; $display("FAIL sb_0x82: mem %h required 11ab3344", mem[32]); end
    preload(8'h84, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 32'h86, 32'h1234_BEEF, r, e);
    checks++; if (mem[33] !== 32'hBEEF_0000) begin errors++; $display("FAIL sh_0x86: mem %h required beef0000", mem[33]); end
    do_req(1'b0, 2'd1, 1'b0, 32'h86, 32'h0, r, e);
    checks++; if (r !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_0x86: got %h required 0000beef", r); end
    do_req(1'b0, 2'd1, 1'b1, 32'h86, 32'h0, r, e);
    checks++; if (r !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_0x86: got %h required ffffbeef", r); end
  endtask

  task automatic test_misaligned();
    logic [31:0] r, exp_r; logic e;
    preload(8'h80, 32'hCAFE_F00D);
    exp_r = ALIGN_EN ? 32'h0 : 32'hCAFE_F00D;
    do_req(1'b0, 2'd2, 1'b0, 32'h81, 32'h0, r, e);
    checks++;
    if (r !== exp_r || e !== ALIGN_EN) begin
      errors++; $display("FAIL lw_0x81: rdata=%h err=%b required %h %b", r, e, exp_r, ALIGN_EN);
    end
  endtask

  task automatic test_reset_abort();
    logic wr_seen;
    preload(8'h80, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h80; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (MemRead !== 1'b1) begin errors++; $display("FAIL abort_in_read: MemRead=%b required 1", MemRead); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || MemRead !== 1'b0 || MemWrite !== 1'b0 || resp_valid !== 1'b0 ||
        Address !== 32'h0 || Write_data !== 32'h0 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL abort_async: ready=%b rd=%b wr=%b rv=%b addr=%h wd=%h rdata=%h required 1 0 0 0 0 0 0",
               req_ready, MemRead, MemWrite, resp_valid, Address, Write_data, resp_rdata);
    end
    wr_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (MemWrite || resp_valid) wr_seen = 1'b1;
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (MemWrite || resp_valid) wr_seen = 1'b1;
    end
    checks++;
    if (wr_seen) begin errors++; $display("FAIL abort_activity: MemWrite or resp_valid seen after reset, required none"); end
    checks++;
    if (mem[32] !== 32'h1122_3344) begin errors++; $display("FAIL abort_mem: mem %h required 11223344", mem[32]); end
    checks++;
    if (req_ready !== 1'b1 || resp_err !== 1'b0 || Address !== 32'h0 || Write_data !== 32'h0 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL abort_release: ready=%b err=%b addr=%h wd=%h rdata=%h required 1 0 0 0 0",
               req_ready, resp_err, Address, Write_data, resp_rdata);
    end
  endtask

  task automatic test_random();
    logic [31:0] r; logic e;
    for (int i = 0; i < 60; i++)
      do_req(1'($urandom), 2'($urandom), 1'($urandom), 32'h80 + $urandom_range(0, 127), $urandom, r, e);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h0;
    test_reset();
    for (int i = 32; i < 64; i++) preload(8'(i * 4), $urandom);
    test_word_rw();
    test_load_ext();
    test_store_sub();
    test_misaligned();
    test_reset_abort();
    for (int i = 32; i < 64; i++) preload(8'(i * 4), $urandom);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
